// File: rtl/btn_pulse_gen.sv
// Push-button conditioner: 2-flop sync, debounce/auto-repeat FSM,
// registered single-cycle enable pulse and debounced level.
module btn_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic RST,
  input  logic BTN,
  output logic EN_PULSE,
  output logic PRESSED
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_DEB_PRESS   = 3'd1;
  localparam logic [2:0] S_HELD_WAIT   = 3'd2;
  localparam logic [2:0] S_REPEAT      = 3'd3;
  localparam logic [2:0] S_DEB_RELEASE = 3'd4;

  localparam logic [CNT_W-1:0] DEB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST =
    CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST =
    CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_s1;
  logic             r_s2;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             r_pressed;

  logic             w_btn_s;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pulse_nxt;
  logic             w_pressed_nxt;

  assign w_btn_s = r_s2;

  // Two-flop synchronizer for the asynchronous button input
  always_ff @(posedge clk) begin
    if (RST) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= BTN;
      r_s2 <= r_s1;
    end
  end

  // Next-state, counter and pulse decisions from the synced level
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_ONE;
    w_pulse_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_btn_s) begin
          w_state_nxt = S_DEB_PRESS;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = CNT_ZERO;
        end
      end
      S_DEB_PRESS: begin
        if (!w_btn_s) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = S_HELD_WAIT;
          w_cnt_nxt   = CNT_ZERO;
          w_pulse_nxt = 1'b1;
        end
      end
      S_HELD_WAIT: begin
        if (!w_btn_s) begin
          w_state_nxt = S_DEB_RELEASE;
          w_cnt_nxt   = CNT_ONE;
        end else if (r_cnt == DLY_LAST) begin
          if (REPEAT_EN != 0) begin
            w_state_nxt = S_REPEAT;
            w_cnt_nxt   = CNT_ZERO;
            w_pulse_nxt = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt;
          end
        end
      end
      S_REPEAT: begin
        if (!w_btn_s) begin
          w_state_nxt = S_DEB_RELEASE;
          w_cnt_nxt   = CNT_ONE;
        end else if (r_cnt == PER_LAST) begin
          w_cnt_nxt   = CNT_ZERO;
          w_pulse_nxt = 1'b1;
        end
      end
      S_DEB_RELEASE: begin
        if (w_btn_s) begin
          w_state_nxt = S_HELD_WAIT;
          w_cnt_nxt   = CNT_ZERO;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // Debounced level follows the states that mean "button is down"
  always_comb begin
    w_pressed_nxt = (w_state_nxt == S_HELD_WAIT) ||
                    (w_state_nxt == S_REPEAT) ||
                    (w_state_nxt == S_DEB_RELEASE);
  end

  // FSM state, counter and registered outputs
  always_ff @(posedge clk) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= CNT_ZERO;
      r_pulse   <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pulse   <= w_pulse_nxt;
      r_pressed <= w_pressed_nxt;
    end
  end

  assign EN_PULSE = r_pulse;
  assign PRESSED  = r_pressed;

endmodule
